// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel, WIDTH-bit registered multiplexer.
// Manual mode: a loaded select register picks the channel.
// Scan mode: round-robin with a programmable dwell; idle channels are skipped.
// The output is one registered valid/ready stage. It never drops or
// overwrites a sample that the consumer has not accepted.
module mux_nx1_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // The dwell counter only needs to reach DWELL-1. Keep at least one bit.
  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_COUNT   = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic [SEL_W-1:0] next_ch;
  logic             load;
  logic             sel_legal;

  // Select the sample and valid flag of the current channel.
  // An out-of-range index selects nothing.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_ch_q == SEL_W'(k)) begin
        sel_data  = in_data[k*WIDTH +: WIDTH];
        sel_valid = in_valid[k];
      end
    end
  end

  // Compute the next output-stage, channel and dwell state.
  always_comb begin
    load      = !out_valid_q || out_ready;
    // Wrap explicitly, so a non-power-of-two channel count never makes an illegal index.
    next_ch   = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
    sel_legal = ({1'b0, sel} < CH_COUNT);

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    cur_ch_d    = cur_ch_q;
    dwell_cnt_d = dwell_cnt_q;

    // A capture always uses the channel selected before this edge.
    if (load) begin
      out_data_d  = sel_data;
      out_ch_d    = cur_ch_q;
      out_valid_d = sel_valid;
    end

    if (!mode) begin
      // Manual mode holds dwell at zero, so a later switch to scan restarts the
      // dwell. A select load does not wait for the output stage.
      dwell_cnt_d = '0;
      if (sel_load && sel_legal) begin
        cur_ch_d = sel;
      end
    end else if (load) begin
      if (!sel_valid || (dwell_cnt_q == DWELL_LAST)) begin
        cur_ch_d    = next_ch;
        dwell_cnt_d = '0;
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end
  end

  // State registers. Reset clears the output stage asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch_q    <= '0;
      dwell_cnt_q <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cur_ch_q    <= cur_ch_d;
      dwell_cnt_q <= dwell_cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed testbench for mux_nx1_scan.
// Instance a: 8 channels, dwell 4. Instance b: 8 channels, dwell 2.
// Instance c: 6 channels, dwell 4.
module tb_mux_nx1_scan;

  logic clk;
  logic rst;

  // Instances a and b share their inputs.
  logic [63:0] d_data;
  logic [7:0]  d_valid;
  logic        d_mode;
  logic [2:0]  d_sel;
  logic        d_sel_load;
  logic        d_ready;
  logic [7:0]  a_data, b_data;
  logic [2:0]  a_ch, b_ch;
  logic        a_valid, b_valid;

  logic [47:0] c_in_data;
  logic [5:0]  c_in_valid;
  logic        c_mode;
  logic [2:0]  c_sel;
  logic        c_sel_load;
  logic        c_ready;
  logic [7:0]  c_data;
  logic [2:0]  c_ch;
  logic        c_valid;

  int total;
  int bad;
  int acc_cnt;
  logic [7:0] acc_last;

  int scan_seq [13] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0, 1};
  int skip_vld [12] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  int skip_ch  [12] = '{0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0};
  int c_seq    [14] = '{3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 0, 0};

  mux_nx1_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .mode(d_mode),
    .sel(d_sel), .sel_load(d_sel_load), .out_data(a_data), .out_ch(a_ch),
    .out_valid(a_valid), .out_ready(d_ready));

  mux_nx1_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(2)) u_b (
    .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .mode(d_mode),
    .sel(d_sel), .sel_load(d_sel_load), .out_data(b_data), .out_ch(b_ch),
    .out_valid(b_valid), .out_ready(d_ready));

  mux_nx1_scan #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DWELL(4)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .mode(c_mode),
    .sel(c_sel), .sel_load(c_sel_load), .out_data(c_data), .out_ch(c_ch),
    .out_valid(c_valid), .out_ready(c_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count the samples that instance a hands to the consumer.
  always @(posedge clk) begin
    if (!rst && a_valid && d_ready) begin
      acc_cnt  = acc_cnt + 1;
      acc_last = a_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) d_data[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    total++;
    if (a_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", a_data); end
    total++;
    if (c_valid !== 1'b0) begin bad++; $display("FAIL reset_c_valid got=%b exp=0", c_valid); end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_manual();
    set_ramp();
    d_valid = 8'hFF;
    d_mode = 1'b0;
    d_ready = 1'b1;
    d_sel = 3'd5;
    d_sel_load = 1'b1;
    step();
    d_sel_load = 1'b0;
    total++;
    if (a_ch !== 3'd0 || a_data !== 8'h10) begin
      bad++; $display("FAIL manual_old_ch got=%0d/%h exp=0/10", a_ch, a_data);
    end
    step();
    total++;
    if (a_data !== 8'h15 || a_ch !== 3'd5 || a_valid !== 1'b1) begin
      bad++; $display("FAIL manual_ch5 got=%h/%0d/%b exp=15/5/1", a_data, a_ch, a_valid);
    end
  endtask

  task automatic test_backpressure();
    d_sel = 3'd2;
    d_sel_load = 1'b1;
    step();
    d_sel_load = 1'b0;
    step();
    d_ready = 1'b0;
    acc_cnt = 0;
    d_data[2*8 +: 8] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (a_data !== 8'h12 || a_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=12/1", i, a_data, a_valid);
      end
    end
    d_ready = 1'b1;
    step();
    total++;
    if (a_data !== 8'hAA) begin bad++; $display("FAIL bp_release got=%h exp=aa", a_data); end
    total++;
    if (acc_cnt !== 1 || acc_last !== 8'h12) begin
      bad++; $display("FAIL bp_accept1 got=%0d/%h exp=1/12", acc_cnt, acc_last);
    end
    step();
    total++;
    if (acc_cnt !== 2 || acc_last !== 8'hAA) begin
      bad++; $display("FAIL bp_accept2 got=%0d/%h exp=2/aa", acc_cnt, acc_last);
    end
  endtask

  task automatic test_scan_dwell();
    set_ramp();
    d_sel = 3'd6;
    d_sel_load = 1'b1;
    step();
    d_sel_load = 1'b0;
    d_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      total++;
      if (a_ch !== 3'(scan_seq[i]) || a_data !== 8'(8'h10 + scan_seq[i]) || a_valid !== 1'b1) begin
        bad++; $display("FAIL scan_seq[%0d] got=%0d/%h exp=%0d", i, a_ch, a_data, scan_seq[i]);
      end
    end
  endtask

  task automatic test_skip_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    d_valid = 8'b0000_0101;
    d_mode = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (b_valid !== 1'(skip_vld[i])) begin
        bad++; $display("FAIL skip_valid[%0d] got=%b exp=%0d", i, b_valid, skip_vld[i]);
      end
      if (skip_vld[i] == 1) begin
        total++;
        if (b_ch !== 3'(skip_ch[i])) begin
          bad++; $display("FAIL skip_ch[%0d] got=%0d exp=%0d", i, b_ch, skip_ch[i]);
        end
      end
    end
    d_valid = 8'h00;
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (b_valid !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, b_valid); end
    end
  endtask

  task automatic test_mode_switch();
    for (int k = 0; k < 6; k++) c_in_data[k*8 +: 8] = 8'(8'h20 + k);
    c_in_valid = 6'h3F;
    c_ready = 1'b1;
    c_mode = 1'b0;
    c_sel = 3'd3;
    c_sel_load = 1'b1;
    step();
    c_sel_load = 1'b0;
    step();
    total++;
    if (c_ch !== 3'd3) begin bad++; $display("FAIL c_sel3 got=%0d exp=3", c_ch); end
    c_sel = 3'd7;
    c_sel_load = 1'b1;
    step();
    c_sel_load = 1'b0;
    step();
    total++;
    if (c_ch !== 3'd3 || c_data !== 8'h23) begin
      bad++; $display("FAIL c_illegal_sel got=%0d/%h exp=3/23", c_ch, c_data);
    end
    c_mode = 1'b1;
    step();
    step();
    c_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (c_ch !== 3'd3) begin bad++; $display("FAIL c_manual_hold[%0d] got=%0d exp=3", i, c_ch); end
    end
    c_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      total++;
      if (c_ch !== 3'(c_seq[i]) || c_data !== 8'(8'h20 + c_seq[i])) begin
        bad++; $display("FAIL c_scan[%0d] got=%0d/%h exp=%0d", i, c_ch, c_data, c_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    set_ramp();
    d_valid = 8'hFF;
    d_mode = 1'b0;
    d_ready = 1'b1;
    d_sel = 3'd4;
    d_sel_load = 1'b1;
    step();
    d_sel_load = 1'b0;
    step();
    d_ready = 1'b0;
    step();
    total++;
    if (a_valid !== 1'b1 || a_ch !== 3'd4) begin
      bad++; $display("FAIL ar_pre got=%b/%0d exp=1/4", a_valid, a_ch);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (a_valid !== 1'b0 || a_data !== 8'h00) begin
      bad++; $display("FAIL ar_async got=%b/%h exp=0/00", a_valid, a_data);
    end
    #1;
    rst = 1'b0;
    d_ready = 1'b1;
    step();
    total++;
    if (a_ch !== 3'd0 || a_data !== 8'h10 || a_valid !== 1'b1) begin
      bad++; $display("FAIL ar_restart got=%0d/%h/%b exp=0/10/1", a_ch, a_data, a_valid);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    acc_cnt = 0;
    acc_last = 8'h00;
    rst = 1'b1;
    d_data = '0;
    d_valid = '0;
    d_mode = 1'b0;
    d_sel = '0;
    d_sel_load = 1'b0;
    d_ready = 1'b1;
    c_in_data = '0;
    c_in_valid = '0;
    c_mode = 1'b0;
    c_sel = '0;
    c_sel_load = 1'b0;
    c_ready = 1'b1;
    test_reset();
    test_manual();
    test_backpressure();
    test_scan_dwell();
    test_skip_idle();
    test_mode_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
